flit_fault_detector: RTL and testbench
======================================

FLIT_FAULT_DETECTOR -- requirements
Module: flit_fault_detector

Interface
REQ-001 Parameter FLIT_WIDTH, default 32, flit data width in bits.
REQ-002 Parameter PARITY_GROUPS, default 4, number of even-parity groups; FLIT_WIDTH SHALL be a multiple of PARITY_GROUPS.
REQ-003 Parameter CNT_WIDTH, default 16, width of the error counter.
REQ-004 Parameter TS_WIDTH, default 16, width of the event timestamp.
REQ-005 Parameter EVENT_DEPTH, default 4, event FIFO depth; SHALL be a power of two, at least 2.
REQ-006 clk  input  1  clock; all logic SHALL sample on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 enable  input  1  checking enable; when low, no error is flagged.
REQ-009 in_flit  input  FLIT_WIDTH  received flit.
REQ-010 in_parity  input  PARITY_GROUPS  per-group even-parity bits from the sender.
REQ-011 in_valid  input  1  in_flit and in_parity are valid this cycle.
REQ-012 out_flit  output  FLIT_WIDTH  registered copy of in_flit, unmodified.
REQ-013 out_valid  output  1  registered in_valid.
REQ-014 out_error  output  1  parity error on the flit currently on out_flit.
REQ-015 err_count  output  CNT_WIDTH  saturating count of erroneous flits.
REQ-016 clear_count  input  1  clears err_count and overflow.
REQ-017 event_valid / event_ready  output / input  1 / 1  error-event handshake towards the debug side.
REQ-018 event_mask  output  PARITY_GROUPS  failing groups of the head event.
REQ-019 event_ts  output  TS_WIDTH  timestamp of the head event.
REQ-020 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-021 Group g SHALL cover flit bits [g*GW +: GW], with GW = FLIT_WIDTH/PARITY_GROUPS.
REQ-022 A group SHALL fail when the XOR of its bits and in_parity[g] is 1.
REQ-023 A flit SHALL be erroneous when in_valid=1, enable=1 and at least one group fails; flits with in_valid=0 SHALL be ignored.
REQ-024 Latency: a flit accepted in cycle N SHALL appear on out_flit/out_valid/out_error in cycle N+1, with one flit accepted per cycle and no backpressure.
REQ-025 err_count SHALL increment in cycle N+1 for each erroneous flit.
REQ-026 err_count SHALL saturate at all-ones.
REQ-027 A free-running timestamp counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-028 The event for an erroneous flit SHALL record the failing-group mask and the timestamp value from cycle N.
REQ-029 The event SHALL be written into the FIFO at the end of cycle N+1; event_valid SHALL rise no earlier than cycle N+2.
REQ-030 A FIFO entry SHALL pop when event_valid and event_ready are both 1.
REQ-031 event_mask and event_ts SHALL be held stable while event_valid=1 and event_ready=0.
REQ-032 A push to a full FIFO with no pop in the same cycle SHALL discard the event and set overflow.
REQ-033 If the FIFO is full and a pop occurs in the same cycle as a push, the push SHALL be accepted.
REQ-034 clear_count SHALL zero err_count and overflow.
REQ-035 clear_count SHALL take priority over a simultaneous increment or overflow set; that error is not counted, but its event is still pushed when space exists.

Reset
REQ-036 On rst: out_flit=0, out_valid=0, out_error=0, err_count=0, overflow=0, timestamp=0, FIFO empty, event_valid=0, all in the cycle after rst is sampled.
REQ-037 A rst mid-operation SHALL discard all pending events and the in-flight flit.

Structure
REQ-038 Package fault_detect_pkg SHALL hold the event record typedef (mask, timestamp) and shared width constants.
REQ-039 The FIFO SHALL be a separate sub-module, fault_event_fifo, with a registered head and full/empty flags.

Verification (FLIT_WIDTH=32, PARITY_GROUPS=4, CNT_WIDTH=16, EVENT_DEPTH=4)
REQ-040 0xDEADBEEF with correct parity, enable=1 -> out_flit=0xDEADBEEF next cycle, out_error=0, err_count=0, no event.
REQ-041 Same flit with bit 13 flipped, timestamp 0x0010 -> out_error=1, err_count=1, event_mask=4'b0010, event_ts=0x0010; invalid flit with bad parity -> nothing flagged.
REQ-042 Five consecutive erroneous flits, event_ready=0 -> err_count=5, 4 events stored, overflow=1; then event_ready=1 -> 4 pops in order, and overflow stays 1.
REQ-043 err_count=0xFFFF plus one error -> err_count stays 0xFFFF; clear_count coincident with an error -> err_count=0, overflow=0, event pushed.
REQ-044 rst asserted with 3 events queued and a flit in flight -> next cycle event_valid=0, out_valid=0, err_count=0, timestamp=0.

Source files
------------

// File: rtl/fault_detect_pkg.sv
// Shared types and constants for the flit fault detector slice.
// Holds the default configuration widths, the event record that travels
// through the event FIFO (failing-group mask + timestamp), and a helper
// that sizes the packed event word for any configuration.
package fault_detect_pkg;

  localparam int DEF_FLIT_WIDTH    = 32;
  localparam int DEF_PARITY_GROUPS = 4;
  localparam int DEF_CNT_WIDTH     = 16;
  localparam int DEF_TS_WIDTH      = 16;
  localparam int DEF_EVENT_DEPTH   = 4;

  // Event record for the default configuration; mask sits in the upper bits,
  // timestamp in the lower bits, matching the packing used by the detector.
  typedef struct packed {
    logic [DEF_PARITY_GROUPS-1:0] mask;
    logic [DEF_TS_WIDTH-1:0]      ts;
  } fault_event_t;

  // Width of one packed event word (mask + timestamp).
  function automatic int eventBits(input int groups, input int tsWidth);
    return groups + tsWidth;
  endfunction

endpackage

// File: rtl/fault_event_fifo.sv
// Small synchronous FIFO holding parity-error events for the debug side.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  write request and event word
//   i_pop           read request (ignored when empty)
//   o_data          head entry, read from the register file at the read
//                   pointer so it stays stable until popped
//   o_full, o_empty registered occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module fault_event_fifo
  import fault_detect_pkg::*;
#(
  parameter int DATA_WIDTH = eventBits(DEF_PARITY_GROUPS, DEF_TS_WIDTH),
  parameter int DEPTH      = DEF_EVENT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW:0]           r_count;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_pop;
  logic                  w_push;
  logic [PW:0]           w_count_next;

  // A pop frees the slot the simultaneous push needs, so full+pop still
  // accepts the write.
  assign w_pop  = i_pop && !r_empty;
  assign w_push = i_push && (!r_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (PW+1)'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - (PW+1)'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (PW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/flit_fault_detector.sv
// Per-group even-parity checker for NoC flits with error counting and an
// event log for a debug agent.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable                    parity checking enable
//   in_flit/in_parity/in_valid  received flit, per-group parity, valid
//   out_flit/out_valid        one-cycle registered copy of the input flit
//   out_error                 parity error on the flit now on out_flit
//   err_count                 saturating error count
//   clear_count               zeroes err_count and overflow
//   event_valid/event_ready   error-event handshake
//   event_mask/event_ts       failing groups and timestamp of head event
//   overflow                  sticky "an event was dropped" flag
// Flit accepted in cycle N: outputs and count update for cycle N+1, the
// event is pushed at the end of N+1 and is visible from N+2.
module flit_fault_detector
  import fault_detect_pkg::*;
#(
  parameter int FLIT_WIDTH    = DEF_FLIT_WIDTH,
  parameter int PARITY_GROUPS = DEF_PARITY_GROUPS,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int TS_WIDTH      = DEF_TS_WIDTH,
  parameter int EVENT_DEPTH   = DEF_EVENT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [FLIT_WIDTH-1:0]    in_flit,
  input  logic [PARITY_GROUPS-1:0] in_parity,
  input  logic                     in_valid,
  output logic [FLIT_WIDTH-1:0]    out_flit,
  output logic                     out_valid,
  output logic                     out_error,
  output logic [CNT_WIDTH-1:0]     err_count,
  input  logic                     clear_count,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [PARITY_GROUPS-1:0] event_mask,
  output logic [TS_WIDTH-1:0]      event_ts,
  output logic                     overflow
);

  localparam int GW   = FLIT_WIDTH / PARITY_GROUPS;
  localparam int EV_W = eventBits(PARITY_GROUPS, TS_WIDTH);

  logic [FLIT_WIDTH-1:0]    r_out_flit;
  logic                     r_out_valid;
  logic                     r_out_error;
  logic [PARITY_GROUPS-1:0] r_ev_mask;
  logic [TS_WIDTH-1:0]      r_ev_ts;
  logic [TS_WIDTH-1:0]      r_ts;
  logic [CNT_WIDTH-1:0]     r_err_count;
  logic                     r_overflow;

  logic [PARITY_GROUPS-1:0] w_fail_mask;
  logic                     w_err;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_drop;
  logic [EV_W-1:0]          w_head;

  // A group fails when its bits plus the sender's parity bit are odd.
  always_comb begin
    w_fail_mask = '0;
    for (int g = 0; g < PARITY_GROUPS; g++) begin
      w_fail_mask[g] = ^{in_parity[g], in_flit[g*GW +: GW]};
    end
  end

  assign w_err = in_valid && enable && (|w_fail_mask);

  // Pipeline stage: output copy plus the event record captured with the
  // timestamp of the accepting cycle. r_out_error doubles as the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_out_error <= 1'b0;
      r_ev_mask   <= '0;
      r_ev_ts     <= '0;
    end else begin
      r_out_flit  <= in_flit;
      r_out_valid <= in_valid;
      r_out_error <= w_err;
      r_ev_mask   <= w_fail_mask;
      r_ev_ts     <= r_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // clear_count wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clear_count) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_WIDTH'(1);
    end
  end

  assign w_pop  = event_ready && !w_empty;
  assign w_drop = r_out_error && w_full && !w_pop;

  // clear_count also wins over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst || clear_count) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  fault_event_fifo #(
    .DATA_WIDTH(EV_W),
    .DEPTH     (EVENT_DEPTH)
  ) u_event_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_out_error),
    .i_data ({r_ev_mask, r_ev_ts}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign out_flit    = r_out_flit;
  assign out_valid   = r_out_valid;
  assign out_error   = r_out_error;
  assign err_count   = r_err_count;
  assign overflow    = r_overflow;
  assign event_valid = !w_empty;
  assign event_mask  = w_head[EV_W-1 -: PARITY_GROUPS];
  assign event_ts    = w_head[TS_WIDTH-1:0];

endmodule

// File: tb/tb_flit_fault_detector.sv
// Self-checking bench for flit_fault_detector in its default configuration.
// A transaction-level model (event queue, integer counters) predicts every
// output each cycle; directed phases pin down the documented scenarios and
// a randomized phase exercises mixed traffic, clears and resets.
module tb_flit_fault_detector;
  import fault_detect_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] in_flit;
  logic [3:0]  in_parity;
  logic        in_valid;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        out_error;
  logic [15:0] err_count;
  logic        clear_count;
  logic        event_valid;
  logic        event_ready;
  logic [3:0]  event_mask;
  logic [15:0] event_ts;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]  mOutFlit;
  bit           mOutValid;
  bit           mOutError;
  int           mCount;
  bit           mOverflow;
  int           mTs;
  bit           mPending;
  fault_event_t mPendEvent;
  fault_event_t evQ[$];

  always #5 clk = ~clk;

  flit_fault_detector #(
    .FLIT_WIDTH   (32),
    .PARITY_GROUPS(4),
    .CNT_WIDTH    (16),
    .TS_WIDTH     (16),
    .EVENT_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_flit    (in_flit),
    .in_parity  (in_parity),
    .in_valid   (in_valid),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_error  (out_error),
    .err_count  (err_count),
    .clear_count(clear_count),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_mask (event_mask),
    .event_ts   (event_ts),
    .overflow   (overflow)
  );

  function automatic logic [3:0] goodParity(input logic [31:0] f);
    logic [3:0] p;
    for (int g = 0; g < 4; g++) begin
      p[g] = ($countones(f[g*8 +: 8]) % 2) == 1;
    end
    return p;
  endfunction

  function automatic logic [3:0] failMask(input logic [31:0] f, input logic [3:0] p);
    logic [3:0] m;
    for (int g = 0; g < 4; g++) begin
      m[g] = (($countones(f[g*8 +: 8]) + int'(p[g])) % 2) == 1;
    end
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge given the inputs of this cycle.
  task automatic modelStep(input bit r, input bit en, input bit v,
                           input logic [31:0] f, input logic [3:0] p,
                           input bit rdy, input bit clr);
    logic [3:0] m;
    bit err;
    bit pop;
    if (r) begin
      mOutFlit = '0; mOutValid = 0; mOutError = 0;
      mCount = 0; mOverflow = 0; mTs = 0; mPending = 0;
      evQ.delete();
      return;
    end
    m   = failMask(f, p);
    err = v && en && (m != 4'b0);
    pop = (evQ.size() != 0) && rdy;
    if (pop) void'(evQ.pop_front());
    if (mPending) begin
      if (evQ.size() < 4) evQ.push_back(mPendEvent);
      else mOverflow = 1;
    end
    if (clr) begin
      mCount = 0;
      mOverflow = 0;
    end else if (err && mCount < 65535) begin
      mCount++;
    end
    mPending        = err;
    mPendEvent.mask = m;
    mPendEvent.ts   = 16'(mTs);
    mOutFlit  = f;
    mOutValid = v;
    mOutError = err;
    mTs = (mTs + 1) % 65536;
  endtask

  task automatic compareAll();
    checkOutput("out_flit", out_flit, mOutFlit);
    checkOutput("out_valid", out_valid, mOutValid);
    checkOutput("out_error", out_error, mOutError);
    checkOutput("err_count", err_count, 64'(mCount));
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("event_valid", event_valid, evQ.size() != 0);
    if (evQ.size() != 0) begin
      checkOutput("event_mask", event_mask, evQ[0].mask);
      checkOutput("event_ts", event_ts, evQ[0].ts);
    end
  endtask

  // One clock cycle: drive inputs, predict, then check after the edge.
  task automatic applyStimulus(input bit r, input bit en, input bit v,
                               input logic [31:0] f, input logic [3:0] p,
                               input bit rdy, input bit clr);
    rst = r; enable = en; in_valid = v; in_flit = f; in_parity = p;
    event_ready = rdy; clear_count = clr;
    modelStep(r, en, v, f, p, rdy, clr);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(0, 1, 0, 32'h0, 4'h0, rdy, 0);
  endtask

  task automatic errFlit(input bit rdy, input bit clr);
    logic [31:0] f;
    f = $urandom;
    applyStimulus(0, 1, 1, f, goodParity(f) ^ 4'(1 << $urandom_range(0, 3)), rdy, clr);
  endtask

  initial begin
    logic [31:0] f;
    logic [3:0]  p;
    rst = 1; enable = 0; in_valid = 0; in_flit = '0; in_parity = '0;
    event_ready = 0; clear_count = 0;

    // Reset state
    applyStimulus(1, 0, 0, 32'h0, 4'h0, 0, 0);
    applyStimulus(1, 0, 0, 32'h0, 4'h0, 0, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_event_valid", event_valid, 0);
    checkOutput("rst_err_count", err_count, 0);

    // Clean flit passes through untouched
    applyStimulus(0, 1, 1, 32'hDEADBEEF, goodParity(32'hDEADBEEF), 0, 0);
    checkOutput("clean_flit", out_flit, 32'hDEADBEEF);
    checkOutput("clean_no_error", out_error, 0);
    checkOutput("clean_count", err_count, 0);
    idle(0);
    checkOutput("clean_no_event", event_valid, 0);

    // Bit 13 flipped at timestamp 0x0010 fails group 1
    while (mTs != 16) idle(0);
    applyStimulus(0, 1, 1, 32'hDEADBEEF ^ 32'h0000_2000, goodParity(32'hDEADBEEF), 0, 0);
    checkOutput("bit13_error", out_error, 1);
    checkOutput("bit13_count", err_count, 1);
    applyStimulus(0, 1, 0, 32'h1234_5678, 4'hF, 0, 0);
    checkOutput("invalid_no_error", out_error, 0);
    checkOutput("invalid_count", err_count, 1);
    idle(0);
    checkOutput("bit13_event_valid", event_valid, 1);
    checkOutput("bit13_event_mask", event_mask, 4'b0010);
    checkOutput("bit13_event_ts", event_ts, 16'h0010);
    idle(1);
    checkOutput("bit13_popped", event_valid, 0);

    // Five errors with the debug side stalled: one event dropped
    applyStimulus(0, 1, 0, 32'h0, 4'h0, 0, 1);
    for (int i = 0; i < 5; i++) errFlit(0, 0);
    idle(0);
    idle(0);
    checkOutput("burst_count", err_count, 5);
    checkOutput("burst_overflow", overflow, 1);
    for (int i = 0; i < 5; i++) idle(1);
    checkOutput("burst_drained", event_valid, 0);
    checkOutput("burst_overflow_sticky", overflow, 1);

    // Counter saturation, then clear coincident with an error
    applyStimulus(0, 1, 0, 32'h0, 4'h0, 1, 1);
    for (int i = 0; i < 65530; i++) errFlit(1, 0);
    for (int i = 0; i < 6; i++) errFlit(0, 0);
    checkOutput("sat_count", err_count, 16'hFFFF);
    checkOutput("sat_overflow", overflow, 1);
    for (int i = 0; i < 6; i++) idle(1);
    errFlit(0, 1);
    checkOutput("clear_count_wins", err_count, 0);
    checkOutput("clear_overflow", overflow, 0);
    idle(0);
    idle(0);
    checkOutput("clear_event_pushed", event_valid, 1);
    idle(1);

    // Reset with queued events and a flit in flight
    for (int i = 0; i < 4; i++) errFlit(0, 0);
    applyStimulus(1, 1, 0, 32'h0, 4'h0, 0, 0);
    checkOutput("midrst_event_valid", event_valid, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_count", err_count, 0);
    errFlit(0, 0);
    idle(0);
    idle(0);
    checkOutput("midrst_ts_zero", event_ts, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      f = $urandom;
      p = goodParity(f);
      if ($urandom_range(0, 2) == 0) p = p ^ 4'($urandom_range(1, 15));
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) != 0, f, p,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
